ddr_read_frame_ctrl: RTL and testbench

//  Read-side frame-buffer controller; the counterpart of the DDR write path.
//  - Synchronises the display-domain frame-start and the writer's buffer-select into sys_clk.
//  - Reads one full frame from whichever ping-pong buffer the writer is NOT filling.
//  - Issues burst read requests to the DDR read master, throttled by free space in the downstream line FIFO.

---
 rtl/ddr_read_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ddr_read_frame_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_read_frame_ctrl.sv
// Read-side frame-buffer controller: reads a whole frame from the ping-pong buffer
// the writer is not filling, issuing bursts only when the line FIFO has room for them.
//
// state | meaning
// IDLE  | waiting for a synchronised frame start
// CHECK | size the next burst and wait for FIFO room
// REQ   | burst request presented, waiting for accept
// DRAIN | all bursts issued, waiting for the remaining beats
// DONE  | one-cycle frame completion
module ddr_read_frame_ctrl #(
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR_0     = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] BASE_ADDR_1     = 32'h0080_0000,
  parameter int                BYTES_PER_BEAT  = 64,
  parameter int                BEATS_PER_FRAME = 32400,
  parameter int                BURST_LEN       = 16,
  parameter int                FIFO_DEPTH      = 512,
  parameter int                LVL_W           = 10
) (
  input  logic              sys_clk,
  input  logic              rst_i,
  input  logic              frame_start_i,
  input  logic              wr_buf_sel_i,
  input  logic [LVL_W-1:0]  fifo_level_i,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [7:0]        rd_len_o,
  input  logic              rd_ack_i,
  input  logic              rd_valid_i,
  output logic              rd_buf_sel_o,
  output logic              frame_busy_o,
  output logic              frame_done_o,
  output logic              overrun_o
);

  localparam int CNT_W = $clog2(BEATS_PER_FRAME + 1);
  localparam int LEN_W = 9;
  localparam int SW    = CNT_W + LVL_W + 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               fs_s1, fs_s2, fs_s3;
  logic               wb_s1, wb_s2;
  logic               start_pulse;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic [LEN_W-1:0]   cur_len_q, cur_len_d;
  logic               rd_req_d;
  logic [ADDR_W-1:0]  rd_addr_d;
  logic [7:0]         rd_len_d;
  logic               buf_sel_d;
  logic               busy_d;
  logic               done_d;
  logic               overrun_d;
  logic [CNT_W-1:0]   rem;
  logic [CNT_W-1:0]   out_cnt;
  logic [LEN_W-1:0]   burst_len;
  logic               fifo_ok;
  logic               rcv_inc;

  assign start_pulse = fs_s2 & ~fs_s3;

  always_ff @(posedge sys_clk) begin
    if (rst_i) begin
      fs_s1        <= 1'b0;
      fs_s2        <= 1'b0;
      fs_s3        <= 1'b0;
      wb_s1        <= 1'b0;
      wb_s2        <= 1'b0;
      state_q      <= S_IDLE;
      addr_q       <= '0;
      req_cnt_q    <= '0;
      rcv_cnt_q    <= '0;
      cur_len_q    <= '0;
      rd_req_o     <= 1'b0;
      rd_addr_o    <= '0;
      rd_len_o     <= '0;
      rd_buf_sel_o <= 1'b0;
      frame_busy_o <= 1'b0;
      frame_done_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      fs_s1        <= frame_start_i;
      fs_s2        <= fs_s1;
      fs_s3        <= fs_s2;
      wb_s1        <= wr_buf_sel_i;
      wb_s2        <= wb_s1;
      state_q      <= state_d;
      addr_q       <= addr_d;
      req_cnt_q    <= req_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
      cur_len_q    <= cur_len_d;
      rd_req_o     <= rd_req_d;
      rd_addr_o    <= rd_addr_d;
      rd_len_o     <= rd_len_d;
      rd_buf_sel_o <= buf_sel_d;
      frame_busy_o <= busy_d;
      frame_done_o <= done_d;
      overrun_o    <= overrun_d;
    end
  end

  // Beats already requested but not yet returned still need FIFO room.
  always_comb begin
    rem       = CNT_W'(BEATS_PER_FRAME) - req_cnt_q;
    burst_len = (SW'(rem) >= SW'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(rem);
    out_cnt   = (req_cnt_q > rcv_cnt_q) ? (req_cnt_q - rcv_cnt_q) : '0;
    fifo_ok   = (SW'(fifo_level_i) + SW'(out_cnt) + SW'(burst_len)) <= SW'(FIFO_DEPTH);
    rcv_inc   = rd_valid_i && (state_q != S_IDLE) &&
                (rcv_cnt_q < CNT_W'(BEATS_PER_FRAME));
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    req_cnt_d = req_cnt_q;
    rcv_cnt_d = rcv_inc ? (rcv_cnt_q + CNT_W'(1)) : rcv_cnt_q;
    cur_len_d = cur_len_q;
    rd_req_d  = rd_req_o;
    rd_addr_d = rd_addr_o;
    rd_len_d  = rd_len_o;
    buf_sel_d = rd_buf_sel_o;
    busy_d    = frame_busy_o;
    done_d    = 1'b0;
    overrun_d = overrun_o | (start_pulse && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          buf_sel_d = ~wb_s2;
          addr_d    = wb_s2 ? BASE_ADDR_0 : BASE_ADDR_1;
          req_cnt_d = '0;
          rcv_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rem == '0) begin
          state_d = S_DRAIN;
        end else if (fifo_ok) begin
          rd_addr_d = addr_q;
          rd_len_d  = 8'(burst_len - LEN_W'(1));
          cur_len_d = burst_len;
          rd_req_d  = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_ack_i) begin
          rd_req_d  = 1'b0;
          addr_d    = addr_q + ADDR_W'(cur_len_q) * ADDR_W'(BYTES_PER_BEAT);
          req_cnt_d = req_cnt_q + CNT_W'(cur_len_q);
          state_d   = S_CHECK;
        end
      end
      S_DRAIN: begin
        if (rcv_cnt_q == CNT_W'(BEATS_PER_FRAME)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddr_read_frame_ctrl.sv
// Bench for ddr_read_frame_ctrl: a responder plays the DDR read master and a monitor
// checks every accepted burst and frame completion against queued expectations.
module tb_ddr_read_frame_ctrl;

  localparam int BPF = 40;

  logic        sys_clk = 1'b0;
  logic        rst_i;
  logic        frame_start_i;
  logic        wr_buf_sel_i;
  logic [9:0]  fifo_level_i;
  logic        rd_req_o;
  logic [31:0] rd_addr_o;
  logic [7:0]  rd_len_o;
  logic        rd_ack_i;
  logic        rd_valid_i;
  logic        rd_buf_sel_o;
  logic        frame_busy_o;
  logic        frame_done_o;
  logic        overrun_o;

  ddr_read_frame_ctrl #(
    .ADDR_W(32), .BASE_ADDR_0(32'h0000_0000), .BASE_ADDR_1(32'h0000_1000),
    .BYTES_PER_BEAT(64), .BEATS_PER_FRAME(BPF), .BURST_LEN(16),
    .FIFO_DEPTH(64), .LVL_W(10)
  ) dut (
    .sys_clk(sys_clk), .rst_i(rst_i), .frame_start_i(frame_start_i),
    .wr_buf_sel_i(wr_buf_sel_i), .fifo_level_i(fifo_level_i),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_len_o(rd_len_o),
    .rd_ack_i(rd_ack_i), .rd_valid_i(rd_valid_i), .rd_buf_sel_o(rd_buf_sel_o),
    .frame_busy_o(frame_busy_o), .frame_done_o(frame_done_o), .overrun_o(overrun_o)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int coincide_cnt = 0;
  int pending = 0;
  int extra_beats = 0;
  bit ack_en = 1'b0;
  bit ret_en = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_len_q[$];
  logic        exp_buf_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Three bursts of 16/16/8 beats from the base of the buffer being read.
  task automatic push_frame(input logic b);
    logic [31:0] base;
    base = b ? 32'h1000 : 32'h0;
    exp_addr_q.push_back(base);          exp_len_q.push_back(8'd15);
    exp_addr_q.push_back(base + 32'h400); exp_len_q.push_back(8'd15);
    exp_addr_q.push_back(base + 32'h800); exp_len_q.push_back(8'd7);
    exp_buf_q.push_back(b);
  endtask

  task automatic start_frame();
    frame_start_i = 1'b1;
    tick(4);
    frame_start_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (done_cnt >= target) ok = 1'b1;
      else tick(1);
    end
    check("wait_frame_done", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_hs(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge sys_clk);
      #3;
      if (hs_cnt >= target) ok = 1'b1;
    end
    check("wait_handshake", {31'd0, ok}, 32'd1);
  endtask

  // Read master: accepts requests when enabled and returns the requested beats.
  initial begin
    rd_ack_i   = 1'b0;
    rd_valid_i = 1'b0;
    forever begin
      @(negedge sys_clk);
      rd_ack_i = 1'b0;
      if (ack_en && rd_req_o) begin
        rd_ack_i = 1'b1;
        pending += int'(rd_len_o) + 1;
      end
      if (extra_beats > 0) begin
        rd_valid_i = 1'b1;
        extra_beats--;
      end else if (ret_en && pending > 0) begin
        rd_valid_i = 1'b1;
        pending--;
      end else begin
        rd_valid_i = 1'b0;
      end
    end
  end

  // Monitor: compares each accepted burst and each frame completion.
  initial begin
    logic        prev_done;
    logic [31:0] ea;
    logic [7:0]  el;
    logic        eb;
    int          beats;
    prev_done = 1'b0;
    beats = 0;
    forever begin
      @(negedge sys_clk);
      #2;
      if (rst_i) begin
        beats = 0;
      end else begin
        if (rd_valid_i && frame_busy_o) beats++;
        if (rd_req_o && rd_ack_i) begin
          hs_cnt++;
          if (rd_valid_i) coincide_cnt++;
          if (exp_addr_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_request: got addr 0x%0h len %0d, none expected", rd_addr_o, rd_len_o);
          end else begin
            ea = exp_addr_q.pop_front();
            el = exp_len_q.pop_front();
            check("req_addr", rd_addr_o, ea);
            check("req_len", {24'd0, rd_len_o}, {24'd0, el});
          end
        end
        if (frame_done_o) begin
          done_cnt++;
          check("done_single_cycle", {31'd0, prev_done}, 32'd0);
          check("frame_beats", beats, BPF);
          if (exp_buf_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got frame_done_o with none expected");
          end else begin
            eb = exp_buf_q.pop_front();
            check("done_buf_sel", {31'd0, rd_buf_sel_o}, {31'd0, eb});
          end
          beats = 0;
        end
      end
      prev_done = frame_done_o;
    end
  end

  initial begin
    int hs0;
    int c0;
    bit saw;
    bit ok;
    rst_i = 1'b1;
    frame_start_i = 1'b0;
    wr_buf_sel_i = 1'b0;
    fifo_level_i = '0;
    tick(3);
    check("rst_outputs", {26'd0, rd_req_o, rd_buf_sel_o, frame_busy_o, frame_done_o, overrun_o, 1'b0}, 32'd0);
    check("rst_addr", rd_addr_o, 32'd0);
    check("rst_len", {24'd0, rd_len_o}, 32'd0);
    rst_i = 1'b0;
    tick(2);

    // Basic frame from buffer 1, with first-request latency.
    ack_en = 1'b1; ret_en = 1'b1; wr_buf_sel_i = 1'b0;
    tick(3);
    push_frame(1'b1);
    frame_start_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      if (i < 4) check("t1_req_early", {31'd0, rd_req_o}, 32'd0);
      if (i == 3) check("t1_accept", {30'd0, frame_busy_o, rd_buf_sel_o}, 32'd3);
      if (i == 4) check("t1_req_at_4", {31'd0, rd_req_o}, 32'd1);
    end
    frame_start_i = 1'b0;
    wait_done(1);
    tick(2);
    check("t1_busy_cleared", {31'd0, frame_busy_o}, 32'd0);

    // FIFO back-pressure: 56 stalls, 48 allows exactly one 16-beat burst.
    ret_en = 1'b0; wr_buf_sel_i = 1'b1; fifo_level_i = 10'd56;
    tick(3);
    push_frame(1'b0);
    start_frame();
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      saw |= rd_req_o;
    end
    check("t2_stall_no_req", {31'd0, saw}, 32'd0);
    hs0 = hs_cnt;
    fifo_level_i = 10'd48;
    wait_hs(hs0 + 1);
    tick(10);
    check("t2_single_burst", hs_cnt, hs0 + 1);
    fifo_level_i = '0;
    ret_en = 1'b1;
    wait_done(2);

    // Request held without accept.
    ack_en = 1'b0; wr_buf_sel_i = 1'b0;
    tick(3);
    push_frame(1'b1);
    start_frame();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rd_req_o) ok = 1'b1;
      else tick(1);
    end
    check("t3_req_seen", {31'd0, ok}, 32'd1);
    hs0 = hs_cnt;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (rd_req_o !== 1'b1 || rd_addr_o !== 32'h1000 || rd_len_o !== 8'd15) ok = 1'b0;
    end
    check("t3_hold_stable", {31'd0, ok}, 32'd1);
    check("t3_no_accept", hs_cnt, hs0);
    ack_en = 1'b1;
    wait_done(3);

    // Second frame start while busy.
    check("t4_overrun_clear", {31'd0, overrun_o}, 32'd0);
    ret_en = 1'b0;
    tick(3);
    push_frame(1'b1);
    hs0 = hs_cnt;
    start_frame();
    wait_hs(hs0 + 3);
    tick(1);
    start_frame();
    tick(3);
    check("t4_overrun_set", {30'd0, overrun_o, frame_busy_o}, 32'd3);
    ret_en = 1'b1;
    wait_done(4);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      saw |= rd_req_o | frame_busy_o;
    end
    check("t4_no_restart", {31'd0, saw}, 32'd0);
    check("t4_overrun_sticky", {31'd0, overrun_o}, 32'd1);

    // Ack and beat coincide; stray beats in IDLE change nothing.
    wr_buf_sel_i = 1'b1;
    tick(3);
    push_frame(1'b0);
    c0 = coincide_cnt;
    start_frame();
    wait_done(5);
    check("t6_coincide", coincide_cnt - c0, 3);
    tick(2);
    extra_beats = 6;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if ({rd_req_o, frame_busy_o, frame_done_o, overrun_o, rd_buf_sel_o} !== 5'b00010 ||
          rd_addr_o !== 32'h800 || rd_len_o !== 8'd7) ok = 1'b0;
    end
    check("t6_idle_beats_ignored", {31'd0, ok}, 32'd1);

    // Reset one cycle after the second burst is accepted.
    wr_buf_sel_i = 1'b0;
    tick(3);
    exp_addr_q.push_back(32'h1000); exp_len_q.push_back(8'd15);
    exp_addr_q.push_back(32'h1400); exp_len_q.push_back(8'd15);
    hs0 = hs_cnt;
    start_frame();
    wait_hs(hs0 + 2);
    ack_en = 1'b0;
    @(posedge sys_clk);
    #1 rst_i = 1'b1;
    @(posedge sys_clk);
    #1 rst_i = 1'b0;
    check("t5_rst_outputs", {27'd0, rd_req_o, rd_buf_sel_o, frame_busy_o, frame_done_o, overrun_o}, 32'd0);
    check("t5_rst_addr_len", rd_addr_o | {24'd0, rd_len_o}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if ({rd_req_o, rd_buf_sel_o, frame_busy_o, frame_done_o, overrun_o} !== 5'b0 ||
          rd_addr_o !== 32'd0) ok = 1'b0;
    end
    check("t5_stale_beats_ignored", {31'd0, ok}, 32'd1);
    ack_en = 1'b1;
    push_frame(1'b1);
    start_frame();
    wait_done(6);

    tick(5);
    check("req_queue_empty", exp_addr_q.size(), 0);
    check("done_queue_empty", exp_buf_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
